acl_tx_arq_sched: RTL and testbench
===================================

// Module: acl_tx_arq_sched
// PURPOSE
// Transmit-side ARQ scheduler for ACL links (Vol2 PartB 7.6.2, 4.5.3). Consumes received ARQN/FLOW
// per LT_ADDR and, at each TX slot, decides whether the packet encoder sends new data, resends the
// old payload, sends a zero-length continue packet (flush), or sends NULL/POLL.
// Sits between the RX header decoder and the TX packet encoder. Owns per-link SEQN and the retransmit counter.
// PARAMETERS
// NLINK   8   number of LT_ADDR slots (index 0 = broadcast)
// RETX_W  4   width of the per-link retransmit counter and of retx_limit
// PORTS
// clk_6M          in   1       6 MHz baseband clock
// rstz            in   1       synchronous active-low reset
// conn_new_p      in   1       new connection (master or slave): reinitialise all links
// tx_req_p        in   1       TX slot decision request for tx_lt_addr
// tx_lt_addr      in   3       link being transmitted to
// buf_valid       in   1       host ACL buffer holds a pending packet for tx_lt_addr
// rx_done_p       in   1       received header decoded
// rx_lt_addr      in   3       LT_ADDR of received header
// rx_hecgood      in   1       HEC check passed
// rx_arqn         in   1       received ARQN (1 = ACK)
// rx_flow         in   1       received FLOW (1 = GO)
// flush_p         in   1       host flush command for flush_lt_addr
// flush_lt_addr   in   3       link to flush
// retx_limit      in   RETX_W  auto-flush threshold; 0 = unlimited
// pk_sel_valid    out  1       pk_sel/tx_seqn valid, 1 cycle after tx_req_p
// pk_sel          out  2       00 NULL/POLL, 01 new, 10 resend old, 11 zero-length continue
// tx_seqn         out  1       SEQN for the selected packet
// buf_release_p   out  NLINK   per-link pulse: host may free the current packet
// flushed_p       out  NLINK   per-link pulse: the release was caused by a flush, not an ACK
// BEHAVIOUR
// - Per-link state: st {IDLE, WAIT_ACK, FLUSH, WAIT_ZACK}, seqn, flow_go, retx_cnt.
// - Reset and conn_new_p (highest priority) apply the same values to every link:
//   st=IDLE, seqn=1, flow_go=1, retx_cnt=0. Outputs reset to 0.
// - RX path, on rx_done_p & rx_hecgood for link L:
//   - flow_go[L] <= rx_flow.
//   - WAIT_ACK & ACK -> IDLE, retx_cnt=0, buf_release_p[L] pulses next cycle.
//   - WAIT_ZACK & ACK -> IDLE, with no release.
//   - NAK -> no change.
//   - rx_hecgood=0 -> the whole header is ignored; flow_go is not updated.
// - flush_p on link L:
//   - In WAIT_ACK -> FLUSH, with buf_release_p[L] and flushed_p[L] pulsing next cycle.
//   - In any other state it is ignored.
//   - flush_p together with an ACK for the same link in the same cycle: the ACK wins and the flush is dropped.
// - TX path: tx_req_p for link L registers the decision; pk_sel_valid pulses for 1 cycle in the next cycle.
//   The rule applied is the first one that matches:
//   1 flow_go[L]=0 -> 00. No state change. retx_cnt is not incremented.
//   2 FLUSH -> 11, seqn toggles, then WAIT_ZACK.
//   3 WAIT_ZACK -> 11 with the same seqn (retransmit of the zero-length packet).
//   4 WAIT_ACK, retx_limit!=0, retx_cnt==retx_limit -> auto-flush. Release and flushed pulse, pk_sel=11,
//     seqn toggles, then WAIT_ZACK, retx_cnt=0.
//   5 WAIT_ACK -> 10 with the same seqn; retx_cnt increments and saturates at all-ones.
//   6 IDLE & buf_valid -> 01, seqn toggles, then WAIT_ACK, retx_cnt=0.
//   7 IDLE & !buf_valid -> 00.
// - Broadcast link (L=0) never waits for ACK. Rule 6 sends 01 with seqn toggled,
//   buf_release_p[0] pulses with pk_sel_valid, and st stays IDLE.
// - rx_done_p and tx_req_p in the same cycle for the same link: the RX update is applied first,
//   and the TX decision uses the post-RX state.
// - Different links update independently in the same cycle, so several release bits may be high at once.
// - tx_seqn carries the post-toggle value. pk_sel and tx_seqn hold their values until the next tx_req_p.
// - Reset asserted mid-operation discards all outstanding packets with no release pulses.
// TESTING
// - New then ACK: L=1, buf_valid=1, tx_req_p -> pk_sel=01, seqn=0.
//   Then rx ARQN=1 -> buf_release_p=8'h02, flushed_p=0. Next tx_req_p with buf_valid=0 -> 00.
// - NAK: after 01 on L=2, rx ARQN=0, tx_req_p x3 -> pk_sel=10 three times with seqn=0, retx_cnt=3.
// - Auto-flush: retx_limit=2, L=3 NAKed twice, third tx_req_p -> pk_sel=11, seqn=1,
//   release and flushed bit 3 high. ACK -> IDLE with no extra release.
// - Flow stop: rx FLOW=0 on L=1, tx_req_p with buf_valid=1 -> 00 and no state change.
//   rx FLOW=1 -> next tx_req_p gives 01.
// - Simultaneous events: ACK and flush_p on L=4 in the same cycle -> release=1, flushed=0.
//   ACK and tx_req_p on L=4 in the same cycle with buf_valid=1 -> pk_sel=01.
// - Broadcast and reset: tx_req_p L=0 -> 01 with buf_release_p[0] pulsing.
//   conn_new_p while L=5 is in WAIT_ACK -> next tx_req_p gives 01 with seqn=0.

Source files
------------

// File: rtl/acl_tx_arq_sched.sv
// Transmit-side ACL ARQ scheduler: tracks per-link SEQN/flow/retransmit state and
// picks new, resend, zero-length continue or NULL/POLL for each TX slot.
module acl_tx_arq_sched #(
  parameter int NLINK  = 8,
  parameter int RETX_W = 4
) (
  input  logic              clk_6M,
  input  logic              rstz,
  input  logic              conn_new_p,
  input  logic              tx_req_p,
  input  logic [2:0]        tx_lt_addr,
  input  logic              buf_valid,
  input  logic              rx_done_p,
  input  logic [2:0]        rx_lt_addr,
  input  logic              rx_hecgood,
  input  logic              rx_arqn,
  input  logic              rx_flow,
  input  logic              flush_p,
  input  logic [2:0]        flush_lt_addr,
  input  logic [RETX_W-1:0] retx_limit,
  output logic              pk_sel_valid,
  output logic [1:0]        pk_sel,
  output logic              tx_seqn,
  output logic [NLINK-1:0]  buf_release_p,
  output logic [NLINK-1:0]  flushed_p
);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_ACK  = 2'd1,
    ST_FLUSH     = 2'd2,
    ST_WAIT_ZACK = 2'd3
  } link_st_e;

  localparam logic [1:0] PK_NULL   = 2'b00;
  localparam logic [1:0] PK_NEW    = 2'b01;
  localparam logic [1:0] PK_RESEND = 2'b10;
  localparam logic [1:0] PK_ZLEN   = 2'b11;

  link_st_e          st_q   [NLINK];
  link_st_e          st_d   [NLINK];
  logic [RETX_W-1:0] retx_q [NLINK];
  logic [RETX_W-1:0] retx_d [NLINK];
  logic [NLINK-1:0]  seqn_q, seqn_d;
  logic [NLINK-1:0]  flow_q, flow_d;
  logic              pk_sel_valid_q, pk_sel_valid_d;
  logic [1:0]        pk_sel_q, pk_sel_d;
  logic              tx_seqn_q, tx_seqn_d;
  logic [NLINK-1:0]  release_q, release_d;
  logic [NLINK-1:0]  flushed_q, flushed_d;

  logic rx_hit, ack_hit, flush_hit, tx_hit;

  // Per link: RX header first, then host flush, then the TX decision on the post-RX state.
  always_comb begin
    st_d           = st_q;
    retx_d         = retx_q;
    seqn_d         = seqn_q;
    flow_d         = flow_q;
    pk_sel_valid_d = 1'b0;
    pk_sel_d       = pk_sel_q;
    tx_seqn_d      = tx_seqn_q;
    release_d      = '0;
    flushed_d      = '0;
    rx_hit         = 1'b0;
    ack_hit        = 1'b0;
    flush_hit      = 1'b0;
    tx_hit         = 1'b0;

    if (conn_new_p) begin
      for (int l = 0; l < NLINK; l++) begin
        st_d[l]   = ST_IDLE;
        retx_d[l] = '0;
      end
      seqn_d = '1;
      flow_d = '1;
    end else begin
      pk_sel_valid_d = tx_req_p;
      for (int l = 0; l < NLINK; l++) begin
        rx_hit    = rx_done_p && rx_hecgood && (int'(rx_lt_addr) == l);
        ack_hit   = rx_hit && rx_arqn;
        flush_hit = flush_p && (int'(flush_lt_addr) == l) && !ack_hit;
        tx_hit    = tx_req_p && (int'(tx_lt_addr) == l);

        if (rx_hit) flow_d[l] = rx_flow;
        if (ack_hit) begin
          if (st_q[l] == ST_WAIT_ACK) begin
            st_d[l]      = ST_IDLE;
            retx_d[l]    = '0;
            release_d[l] = 1'b1;
          end else if (st_q[l] == ST_WAIT_ZACK) begin
            st_d[l] = ST_IDLE;
          end
        end

        if (flush_hit && (st_d[l] == ST_WAIT_ACK)) begin
          st_d[l]      = ST_FLUSH;
          release_d[l] = 1'b1;
          flushed_d[l] = 1'b1;
        end

        if (tx_hit) begin
          if (!flow_d[l]) begin
            pk_sel_d = PK_NULL;
          end else begin
            case (st_d[l])
              ST_FLUSH: begin
                pk_sel_d  = PK_ZLEN;
                seqn_d[l] = ~seqn_d[l];
                st_d[l]   = ST_WAIT_ZACK;
              end
              ST_WAIT_ZACK: pk_sel_d = PK_ZLEN;
              ST_WAIT_ACK: begin
                if ((retx_limit != '0) && (retx_d[l] == retx_limit)) begin
                  pk_sel_d     = PK_ZLEN;
                  seqn_d[l]    = ~seqn_d[l];
                  st_d[l]      = ST_WAIT_ZACK;
                  retx_d[l]    = '0;
                  release_d[l] = 1'b1;
                  flushed_d[l] = 1'b1;
                end else begin
                  pk_sel_d = PK_RESEND;
                  if (retx_d[l] != '1) retx_d[l] = retx_d[l] + 1'b1;
                end
              end
              default: begin
                if (buf_valid) begin
                  pk_sel_d  = PK_NEW;
                  seqn_d[l] = ~seqn_d[l];
                  retx_d[l] = '0;
                  // Broadcast is never acknowledged, so the buffer is freed on send.
                  if (l == 0) release_d[l] = 1'b1;
                  else        st_d[l]      = ST_WAIT_ACK;
                end else begin
                  pk_sel_d = PK_NULL;
                end
              end
            endcase
          end
          tx_seqn_d = seqn_d[l];
        end
      end
    end
  end

  always_ff @(posedge clk_6M) begin
    if (!rstz) begin
      for (int l = 0; l < NLINK; l++) begin
        st_q[l]   <= ST_IDLE;
        retx_q[l] <= '0;
      end
      seqn_q         <= '1;
      flow_q         <= '1;
      pk_sel_valid_q <= 1'b0;
      pk_sel_q       <= PK_NULL;
      tx_seqn_q      <= 1'b0;
      release_q      <= '0;
      flushed_q      <= '0;
    end else begin
      st_q           <= st_d;
      retx_q         <= retx_d;
      seqn_q         <= seqn_d;
      flow_q         <= flow_d;
      pk_sel_valid_q <= pk_sel_valid_d;
      pk_sel_q       <= pk_sel_d;
      tx_seqn_q      <= tx_seqn_d;
      release_q      <= release_d;
      flushed_q      <= flushed_d;
    end
  end

  assign pk_sel_valid  = pk_sel_valid_q;
  assign pk_sel        = pk_sel_q;
  assign tx_seqn       = tx_seqn_q;
  assign buf_release_p = release_q;
  assign flushed_p     = flushed_q;

endmodule

// File: tb/tb_acl_tx_arq_sched.sv
// Self-checking bench for acl_tx_arq_sched: a per-cycle reference model of the ARQ
// rules compared against the DUT, plus hand-computed directed expectations.
module tb_acl_tx_arq_sched;

  localparam int S_IDLE = 0;
  localparam int S_WACK = 1;
  localparam int S_FLSH = 2;
  localparam int S_ZACK = 3;

  logic       clk_6M;
  logic       rstz;
  logic       conn_new_p;
  logic       tx_req_p;
  logic [2:0] tx_lt_addr;
  logic       buf_valid;
  logic       rx_done_p;
  logic [2:0] rx_lt_addr;
  logic       rx_hecgood;
  logic       rx_arqn;
  logic       rx_flow;
  logic       flush_p;
  logic [2:0] flush_lt_addr;
  logic [3:0] retx_limit;
  logic       pk_sel_valid;
  logic [1:0] pk_sel;
  logic       tx_seqn;
  logic [7:0] buf_release_p;
  logic [7:0] flushed_p;

  int total = 0;
  int bad   = 0;
  bit check_en = 0;

  int   m_st   [8];
  int   m_retx [8];
  bit   m_seqn [8];
  bit   m_flow [8];
  bit   exp_valid;
  int   exp_sel;
  bit   exp_seqn;
  logic [7:0] exp_rel;
  logic [7:0] exp_fl;

  acl_tx_arq_sched #(.NLINK(8), .RETX_W(4)) dut (
    .clk_6M        (clk_6M),
    .rstz          (rstz),
    .conn_new_p    (conn_new_p),
    .tx_req_p      (tx_req_p),
    .tx_lt_addr    (tx_lt_addr),
    .buf_valid     (buf_valid),
    .rx_done_p     (rx_done_p),
    .rx_lt_addr    (rx_lt_addr),
    .rx_hecgood    (rx_hecgood),
    .rx_arqn       (rx_arqn),
    .rx_flow       (rx_flow),
    .flush_p       (flush_p),
    .flush_lt_addr (flush_lt_addr),
    .retx_limit    (retx_limit),
    .pk_sel_valid  (pk_sel_valid),
    .pk_sel        (pk_sel),
    .tx_seqn       (tx_seqn),
    .buf_release_p (buf_release_p),
    .flushed_p     (flushed_p)
  );

  initial clk_6M = 1'b0;
  always #5 clk_6M = ~clk_6M;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got=%0h want=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic modelInitLinks();
    for (int l = 0; l < 8; l++) begin
      m_st[l]   = S_IDLE;
      m_retx[l] = 0;
      m_seqn[l] = 1'b1;
      m_flow[l] = 1'b1;
    end
  endtask

  // Predicts the outputs that follow the next rising edge from the inputs now applied.
  task automatic modelStep();
    int ack_link;
    int l;
    exp_valid = 1'b0;
    exp_rel   = '0;
    exp_fl    = '0;
    if (!rstz) begin
      modelInitLinks();
      exp_sel  = 0;
      exp_seqn = 1'b0;
    end else if (conn_new_p) begin
      modelInitLinks();
    end else begin
      ack_link = -1;
      if (rx_done_p && rx_hecgood) begin
        l = int'(rx_lt_addr);
        m_flow[l] = rx_flow;
        if (rx_arqn) begin
          ack_link = l;
          if (m_st[l] == S_WACK) begin
            m_st[l] = S_IDLE;
            m_retx[l] = 0;
            exp_rel[l] = 1'b1;
          end else if (m_st[l] == S_ZACK) begin
            m_st[l] = S_IDLE;
          end
        end
      end
      if (flush_p) begin
        l = int'(flush_lt_addr);
        if (l != ack_link && m_st[l] == S_WACK) begin
          m_st[l] = S_FLSH;
          exp_rel[l] = 1'b1;
          exp_fl[l]  = 1'b1;
        end
      end
      if (tx_req_p) begin
        l = int'(tx_lt_addr);
        exp_valid = 1'b1;
        if (!m_flow[l]) exp_sel = 0;
        else if (m_st[l] == S_FLSH) begin
          exp_sel = 3; m_seqn[l] = !m_seqn[l]; m_st[l] = S_ZACK;
        end else if (m_st[l] == S_ZACK) exp_sel = 3;
        else if (m_st[l] == S_WACK && retx_limit != 0 && m_retx[l] == int'(retx_limit)) begin
          exp_sel = 3; m_seqn[l] = !m_seqn[l]; m_st[l] = S_ZACK; m_retx[l] = 0;
          exp_rel[l] = 1'b1; exp_fl[l] = 1'b1;
        end else if (m_st[l] == S_WACK) begin
          exp_sel = 2;
          if (m_retx[l] < 15) m_retx[l]++;
        end else if (buf_valid) begin
          exp_sel = 1; m_seqn[l] = !m_seqn[l]; m_retx[l] = 0;
          if (l == 0) exp_rel[0] = 1'b1;
          else        m_st[l] = S_WACK;
        end else exp_sel = 0;
        exp_seqn = m_seqn[l];
      end
    end
  endtask

  // Compare the DUT against the model each cycle, then advance the model.
  always @(negedge clk_6M) begin
    if (check_en) begin
      checkOutput("pk_sel_valid", 32'(pk_sel_valid), 32'(exp_valid));
      checkOutput("pk_sel", 32'(pk_sel), 32'(exp_sel));
      checkOutput("tx_seqn", 32'(tx_seqn), 32'(exp_seqn));
      checkOutput("buf_release_p", 32'(buf_release_p), 32'(exp_rel));
      checkOutput("flushed_p", 32'(flushed_p), 32'(exp_fl));
    end
    modelStep();
  end

  task automatic tick();
    @(posedge clk_6M);
    #1;
  endtask

  task automatic applyStimulus(input bit tx, input logic [2:0] txa, input bit bv,
                               input bit rx, input logic [2:0] rxa, input bit hec,
                               input bit arqn, input bit flow,
                               input bit fl, input logic [2:0] fla, input bit cn);
    tx_req_p = tx; tx_lt_addr = txa; buf_valid = bv;
    rx_done_p = rx; rx_lt_addr = rxa; rx_hecgood = hec; rx_arqn = arqn; rx_flow = flow;
    flush_p = fl; flush_lt_addr = fla; conn_new_p = cn;
    tick();
    tx_req_p = 1'b0; rx_done_p = 1'b0; flush_p = 1'b0; conn_new_p = 1'b0;
  endtask

  task automatic doTx(input logic [2:0] a, input bit bv);
    applyStimulus(1, a, bv, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic doRx(input logic [2:0] a, input bit hec, input bit arqn, input bit flow);
    applyStimulus(0, 0, 0, 1, a, hec, arqn, flow, 0, 0, 0);
  endtask

  task automatic expectTx(input string name, input logic [1:0] sel, input bit sq);
    checkOutput({name, ".valid"}, 32'(pk_sel_valid), 32'd1);
    checkOutput({name, ".sel"}, 32'(pk_sel), 32'(sel));
    checkOutput({name, ".seqn"}, 32'(tx_seqn), 32'(sq));
  endtask

  initial begin
    rstz = 1'b0; conn_new_p = 0; tx_req_p = 0; tx_lt_addr = 0; buf_valid = 0;
    rx_done_p = 0; rx_lt_addr = 0; rx_hecgood = 0; rx_arqn = 0; rx_flow = 0;
    flush_p = 0; flush_lt_addr = 0; retx_limit = 4'd0;
    repeat (3) tick();
    check_en = 1'b1;
    checkOutput("reset.valid", 32'(pk_sel_valid), 32'd0);
    checkOutput("reset.sel", 32'(pk_sel), 32'd0);
    checkOutput("reset.release", 32'(buf_release_p), 32'd0);
    rstz = 1'b1;
    tick();

    // New data then ACK on link 1
    doTx(3'd1, 1);             expectTx("new1", 2'b01, 0);
    doRx(3'd1, 1, 1, 1);
    checkOutput("ack1.release", 32'(buf_release_p), 32'h02);
    checkOutput("ack1.flushed", 32'(flushed_p), 32'h00);
    doTx(3'd1, 0);             expectTx("idle1", 2'b00, 0);

    // NAK on link 2: three resends with unchanged SEQN
    doTx(3'd2, 1);             expectTx("new2", 2'b01, 0);
    doRx(3'd2, 1, 0, 1);
    checkOutput("nak2.release", 32'(buf_release_p), 32'h00);
    for (int i = 0; i < 3; i++) begin
      doTx(3'd2, 1);           expectTx("resend2", 2'b10, 0);
    end
    checkOutput("model.retx2", 32'(m_retx[2]), 32'd3);
    for (int i = 0; i < 14; i++) doTx(3'd2, 1);
    checkOutput("model.retx2_sat", 32'(m_retx[2]), 32'd15);
    expectTx("resend2_sat", 2'b10, 0);

    // Auto-flush on link 3 with limit 2
    retx_limit = 4'd2;
    doTx(3'd3, 1);             expectTx("new3", 2'b01, 0);
    doRx(3'd3, 1, 0, 1);
    doTx(3'd3, 1);             expectTx("resend3a", 2'b10, 0);
    doRx(3'd3, 1, 0, 1);
    doTx(3'd3, 1);             expectTx("resend3b", 2'b10, 0);
    doRx(3'd3, 1, 0, 1);
    doTx(3'd3, 1);             expectTx("autoflush3", 2'b11, 1);
    checkOutput("autoflush3.release", 32'(buf_release_p), 32'h08);
    checkOutput("autoflush3.flushed", 32'(flushed_p), 32'h08);
    doTx(3'd3, 1);             expectTx("zlen_retx3", 2'b11, 1);
    doRx(3'd3, 1, 1, 1);
    checkOutput("zack3.release", 32'(buf_release_p), 32'h00);
    retx_limit = 4'd0;

    // Flow stop and resume on link 1, then a bad-HEC header that must be ignored
    doRx(3'd1, 1, 0, 0);
    doTx(3'd1, 1);             expectTx("flowstop1", 2'b00, 0);
    doRx(3'd1, 1, 0, 1);
    doTx(3'd1, 1);             expectTx("flowgo1", 2'b01, 1);
    doRx(3'd1, 0, 1, 0);
    checkOutput("badhec1.release", 32'(buf_release_p), 32'h00);
    doTx(3'd1, 1);             expectTx("badhec1.resend", 2'b10, 1);

    // Simultaneous events on link 4
    doTx(3'd4, 1);             expectTx("new4", 2'b01, 0);
    applyStimulus(0, 0, 0, 1, 3'd4, 1, 1, 1, 1, 3'd4, 0);
    checkOutput("ackflush4.release", 32'(buf_release_p), 32'h10);
    checkOutput("ackflush4.flushed", 32'(flushed_p), 32'h00);
    doTx(3'd4, 1);             expectTx("new4b", 2'b01, 1);
    applyStimulus(1, 3'd4, 1, 1, 3'd4, 1, 1, 1, 0, 0, 0);
    expectTx("acktx4", 2'b01, 0);
    checkOutput("acktx4.release", 32'(buf_release_p), 32'h10);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 3'd4, 0);
    checkOutput("flush4.release", 32'(buf_release_p), 32'h10);
    checkOutput("flush4.flushed", 32'(flushed_p), 32'h10);
    doTx(3'd4, 1);             expectTx("flushzlen4", 2'b11, 1);
    doRx(3'd4, 1, 1, 1);
    checkOutput("zack4.release", 32'(buf_release_p), 32'h00);

    // Broadcast is released on send and never waits for ACK
    doTx(3'd0, 1);             expectTx("bcast0a", 2'b01, 0);
    checkOutput("bcast0a.release", 32'(buf_release_p), 32'h01);
    doTx(3'd0, 1);             expectTx("bcast0b", 2'b01, 1);

    // Two links release in the same cycle: ACK on 7, flush on 6
    doTx(3'd6, 1);
    doTx(3'd7, 1);
    applyStimulus(0, 0, 0, 1, 3'd7, 1, 1, 1, 1, 3'd6, 0);
    checkOutput("multi.release", 32'(buf_release_p), 32'hC0);
    checkOutput("multi.flushed", 32'(flushed_p), 32'h40);

    // New connection while link 5 waits for ACK
    doTx(3'd5, 1);             expectTx("new5", 2'b01, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    doTx(3'd5, 1);             expectTx("connnew5", 2'b01, 0);

    // Reset mid-operation drops the outstanding packet silently
    doTx(3'd6, 1);             expectTx("new6", 2'b01, 0);
    rstz = 1'b0;
    tick();
    checkOutput("midreset.valid", 32'(pk_sel_valid), 32'd0);
    checkOutput("midreset.release", 32'(buf_release_p), 32'h00);
    rstz = 1'b1;
    doTx(3'd6, 1);             expectTx("after_reset6", 2'b01, 0);
    repeat (2) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
